// File: rtl/fifo_pkt_framer.sv
// Pops words from a synchronous FIFO, groups them into fixed-length packets and appends a
// modular-sum checksum beat; output is a valid/ready stream backed by a 2-entry buffer.
module fifo_pkt_framer #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned PKT_WORDS  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_cs,
   output logic                  fifo_rd_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last
);

   localparam int unsigned CW = $clog2(PKT_WORDS + 1);
   localparam logic [CW-1:0] PktCnt = CW'(PKT_WORDS);

   typedef enum logic {StFetch, StCsum} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         issued_q, issued_d;
   logic [CW-1:0]         captured_q, captured_d;
   logic [DATA_WIDTH-1:0] csum_q, csum_d;
   logic                  inflight_q;

   logic [DATA_WIDTH-1:0] buf_data_q [2];
   logic                  buf_last_q [2];
   logic                  wr_ptr_q, rd_ptr_q;
   logic [1:0]            occ_q, occ_d;

   logic                  pop;
   logic                  push;
   logic [DATA_WIDTH-1:0] push_data;
   logic                  push_last;
   logic [2:0]            level;

   assign m_valid = (occ_q != 2'd0);
   assign pop     = m_valid && m_ready;
   assign m_data  = m_valid ? buf_data_q[rd_ptr_q] : '0;
   assign m_last  = m_valid && buf_last_q[rd_ptr_q];
   assign fifo_cs = fifo_rd_en;

   // Buffer slots already claimed after this cycle's pop, counting the word in flight.
   assign level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

   // Gated by rst_n so the request is also low while reset is held.
   assign fifo_rd_en = rst_n && en && !fifo_empty && (state_q == StFetch) &&
                       (issued_q < PktCnt) && (level < 3'd2);

   always_comb begin
      state_d    = state_q;
      issued_d   = issued_q;
      captured_d = captured_q;
      csum_d     = csum_q;
      push       = 1'b0;
      push_data  = fifo_data;
      push_last  = 1'b0;

      if (fifo_rd_en) begin
         issued_d = issued_q + CW'(1);
      end

      if (inflight_q) begin
         push       = 1'b1;
         csum_d     = csum_q + fifo_data;
         captured_d = captured_q + CW'(1);
         if (captured_d == PktCnt) begin
            state_d = StCsum;
         end
      end

      // No capture can coincide with this: CSUM is entered after the last capture.
      if (state_q == StCsum && (occ_q != 2'd2 || pop)) begin
         push       = 1'b1;
         push_data  = csum_q;
         push_last  = 1'b1;
         csum_d     = '0;
         issued_d   = '0;
         captured_d = '0;
         state_d    = StFetch;
      end
   end

   always_comb begin
      occ_d = occ_q;
      case ({push, pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StFetch;
         issued_q   <= '0;
         captured_q <= '0;
         csum_q     <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         issued_q   <= issued_d;
         captured_q <= captured_d;
         csum_q     <= csum_d;
         inflight_q <= fifo_rd_en;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            buf_data_q[i] <= '0;
            buf_last_q[i] <= 1'b0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
      end else begin
         if (push) begin
            buf_data_q[wr_ptr_q] <= push_data;
            buf_last_q[wr_ptr_q] <= push_last;
            wr_ptr_q             <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         occ_q <= occ_d;
      end
   end

endmodule

// File: tb/tb_fifo_pkt_framer.sv
// Bench for fifo_pkt_framer: behavioural FIFO source, scoreboard of expected beats,
// table of packets plus hand-written stall, backpressure and reset sequences.
module tb_fifo_pkt_framer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        fifo_empty;
   logic [31:0] fifo_data;
   logic        fifo_cs;
   logic        fifo_rd_en;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic        m_last;

   always #5 clk = ~clk;

   fifo_pkt_framer #(
      .DATA_WIDTH(32),
      .PKT_WORDS (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .fifo_empty(fifo_empty),
      .fifo_data (fifo_data),
      .fifo_cs   (fifo_cs),
      .fifo_rd_en(fifo_rd_en),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_last    (m_last)
   );

   // Source FIFO model: the bench owns wp, the read process owns rp.
   logic [31:0] mem [256];
   int          wp = 0;
   int          rp = 0;

   assign fifo_empty = (wp == rp);

   always @(posedge clk) begin
      if (fifo_rd_en) begin
         fifo_data <= mem[rp & 255];
         rp        <= rp + 1;
      end
   end

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } beat_t;

   typedef struct packed {
      logic [3:0][31:0] w;
      logic [31:0]      csum;
   } vec_t;

   beat_t exp_q[$];
   vec_t  vecs [4];
   int    checks   = 0;
   int    failures = 0;
   int    rd_cnt   = 0;
   int    beats    = 0;
   int    first_rd;
   int    first_v;
   logic  last_rd;
   logic  last_valid;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic put_word(input logic [31:0] d);
      mem[wp & 255] = d;
      wp++;
      exp_q.push_back({d, 1'b0});
   endtask

   task automatic exp_csum(input logic [31:0] c);
      exp_q.push_back({c, 1'b1});
   endtask

   task automatic load_pkt(input vec_t v);
      for (int i = 0; i < 4; i++) put_word(v.w[i]);
      exp_csum(v.csum);
   endtask

   task automatic set_vec(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] d, input logic [31:0] cs);
      vecs[idx].w[0] = a;
      vecs[idx].w[1] = b;
      vecs[idx].w[2] = c;
      vecs[idx].w[3] = d;
      vecs[idx].csum = cs;
   endtask

   // Samples the current cycle at its negedge, then advances to just after the next posedge.
   task automatic tick();
      beat_t e;
      @(negedge clk);
      last_rd    = fifo_rd_en;
      last_valid = m_valid;
      if (fifo_rd_en) rd_cnt++;
      chk("cs_eq_rd_en", fifo_cs, fifo_rd_en);
      chk("rd_while_empty", fifo_rd_en && fifo_empty, 0);
      if (rst_n && m_valid && m_ready) begin
         beats++;
         chk("beat_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("beat_data", m_data, e.data);
            chk("beat_last", m_last, e.last);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int budget, input string name);
      int n = 0;
      first_rd = -1;
      first_v  = -1;
      while ((exp_q.size() != 0 || m_valid) && n < budget) begin
         tick();
         if (last_rd && first_rd < 0) first_rd = n;
         if (last_valid && first_v < 0) first_v = n;
         n++;
      end
      chk({name, "_drained"}, exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rd0;
      int b0;
      int n;

      set_vec(0, 32'd1, 32'd2, 32'd3, 32'd4, 32'h0000000A);
      set_vec(1, 32'hFFFFFFFF, 32'h00000002, 32'd0, 32'd0, 32'h00000001);
      set_vec(2, 32'h80000000, 32'h80000000, 32'h12345678, 32'd0, 32'h12345678);
      set_vec(3, 32'h10000000, 32'h20000000, 32'h30000000, 32'hF0000005, 32'h50000005);

      rst_n   = 1'b0;
      en      = 1'b1;
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      tick();
      tick();
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_cs", fifo_cs, 0);
      rst_n = 1'b1;
      tick();

      // Table of packets: payload and checksum via scoreboard, 2-cycle first-beat latency.
      for (int v = 0; v < 4; v++) begin
         load_pkt(vecs[v]);
         drain(40, "vec");
         chk("vec_latency", 64'(first_v - first_rd), 2);
         chk("vec_first_rd", 64'(first_rd), 0);
      end

      // Back-to-back: two packets preloaded, check the per-cycle valid/read pattern.
      for (int i = 1; i <= 8; i++) begin
         put_word(32'(i));
         if (i == 4) exp_csum(32'd10);
      end
      exp_csum(32'd26);
      for (int i = 0; i < 14; i++) begin
         tick();
         chk("tput_valid", last_valid, (i >= 2 && i <= 6) || (i >= 8 && i <= 12));
         chk("tput_rd_en", last_rd, (i <= 3) || (i >= 6 && i <= 9));
      end
      drain(20, "tput");

      // Backpressure from the first beat.
      m_ready = 1'b0;
      rd0     = rd_cnt;
      set_vec(0, 32'd5, 32'd6, 32'd7, 32'd8, 32'h1A);
      load_pkt(vecs[0]);
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i >= 2) begin
            chk("bp_valid", m_valid, 1);
            chk("bp_head", m_data, 32'd5);
         end
      end
      chk("bp_reads", 64'(rd_cnt - rd0), 2);
      m_ready = 1'b1;
      drain(30, "bp");

      // Empty FIFO mid-packet.
      rd0 = rd_cnt;
      b0  = beats;
      put_word(32'h100);
      put_word(32'h200);
      repeat (12) tick();
      chk("empty_beats", 64'(beats - b0), 2);
      chk("empty_reads", 64'(rd_cnt - rd0), 2);
      chk("empty_rd_low", fifo_rd_en, 0);
      put_word(32'h300);
      put_word(32'h400);
      exp_csum(32'hA00);
      drain(30, "empty");

      // en dropped after two reads.
      rd0 = rd_cnt;
      b0  = beats;
      put_word(32'h11);
      put_word(32'h22);
      put_word(32'h33);
      put_word(32'h44);
      exp_csum(32'hAA);
      tick();
      tick();
      en = 1'b0;
      repeat (10) tick();
      chk("en_reads", 64'(rd_cnt - rd0), 2);
      chk("en_beats", 64'(beats - b0), 2);
      en = 1'b1;
      drain(30, "en");

      // Reset after two payload beats; the next packet must not include the discarded words.
      b0 = beats;
      put_word(32'h1000);
      put_word(32'h2000);
      put_word(32'h3000);
      put_word(32'h4000);
      exp_csum(32'hA000);
      n = 0;
      while (beats - b0 < 2 && n < 20) begin
         tick();
         n++;
      end
      chk("rstmid_two_beats", 64'(beats - b0), 2);
      rst_n = 1'b0;
      #1;
      chk("rstmid_m_valid", m_valid, 0);
      chk("rstmid_m_data", m_data, 0);
      chk("rstmid_m_last", m_last, 0);
      chk("rstmid_rd_en", fifo_rd_en, 0);
      exp_q.delete();
      wp = rp;
      set_vec(0, 32'd7, 32'd8, 32'd9, 32'd10, 32'h22);
      load_pkt(vecs[0]);
      tick();
      chk("rstmid_hold_rd", fifo_rd_en, 0);
      tick();
      chk("rstmid_hold_valid", m_valid, 0);
      rst_n = 1'b1;
      drain(40, "rstmid");
      chk("rstmid_latency", 64'(first_v - first_rd), 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
